// File: rtl/trsq8_timer.sv
// trsq8_timer: 8-bit interval timer on the TRSQ8 peripheral bus.
// Four registers at BASE_ADDR..BASE_ADDR+3: CTRL, PERIOD, COUNT, STATUS.
module trsq8_timer #(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk_ip,
  input  logic       reset_ip,
  input  logic [7:0] addr_ip,
  input  logic [7:0] data_ip,
  output logic [7:0] data_op,
  input  logic       wr_en_ip,
  input  logic       rd_en_ip,
  output logic       irq_op
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 4;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PERIOD = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic          en_q, en_d;
  logic          auto_q, auto_d;
  logic          irq_en_q, irq_en_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [DW-1:0] period_q, period_d;
  logic [DW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;

  logic          sel;
  logic          wr_ctrl, wr_period, wr_count, wr_status;
  logic          tick;
  logic          ovf_evt;
  logic [DW-1:0] rdata;

  // Address decode and write strobes per register.
  always_comb begin
    sel       = (addr_ip[7:2] == BASE_ADDR[7:2]);
    wr_ctrl   = sel && wr_en_ip && (addr_ip[1:0] == OFF_CTRL);
    wr_period = sel && wr_en_ip && (addr_ip[1:0] == OFF_PERIOD);
    wr_count  = sel && wr_en_ip && (addr_ip[1:0] == OFF_COUNT);
    wr_status = sel && wr_en_ip && (addr_ip[1:0] == OFF_STATUS);
  end

  // Prescaler tick; a COUNT write in the same cycle swallows the counter event.
  always_comb begin
    tick    = en_q && (pc_q == presc_q);
    ovf_evt = tick && !wr_count && (count_q >= period_q);
  end

  // Next-state: timer progression first, then bus writes override.
  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    presc_d  = presc_q;
    pc_d     = pc_q;
    period_d = period_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (en_q) begin
      pc_d = tick ? '0 : PW'(pc_q + PW'(1));
    end

    if (tick && !wr_count) begin
      count_d = ovf_evt ? '0 : DW'(count_q + DW'(1));
    end

    // Overflow set has priority over a same-cycle write-1-clear.
    if (wr_status && data_ip[0]) begin
      ovf_d = 1'b0;
    end
    if (ovf_evt) begin
      ovf_d = 1'b1;
      if (!auto_q) begin
        en_d = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_d     = data_ip[0];
      auto_d   = data_ip[1];
      irq_en_d = data_ip[2];
      presc_d  = data_ip[7:4];
      if (!en_q && data_ip[0]) begin
        pc_d = '0;
      end
    end
    if (wr_period) begin
      period_d = data_ip;
    end
    if (wr_count) begin
      count_d = data_ip;
    end

    irq_d = ovf_d && irq_en_d;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      presc_q  <= '0;
      pc_q     <= '0;
      period_q <= 8'hFF;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      irq_en_q <= irq_en_d;
      presc_q  <= presc_d;
      pc_q     <= pc_d;
      period_q <= period_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Zero-latency read mux; drives zero when not selected so responders can be OR-ed.
  always_comb begin
    rdata = '0;
    if (sel && rd_en_ip) begin
      case (addr_ip[1:0])
        OFF_CTRL:   rdata = {presc_q, 1'b0, irq_en_q, auto_q, en_q};
        OFF_PERIOD: rdata = period_q;
        OFF_COUNT:  rdata = count_q;
        default:    rdata = {6'b0, en_q, ovf_q};
      endcase
    end
  end

  assign data_op = rdata;
  assign irq_op  = irq_q;

endmodule

// File: tb/tb_trsq8_timer.sv
// Self-checking bench for trsq8_timer: directed scenarios plus random bus traffic
// compared against a cycle-level behavioural model of the register map.
module tb_trsq8_timer;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk;
  logic       reset_ip;
  logic [7:0] addr_ip;
  logic [7:0] data_ip;
  logic [7:0] data_op;
  logic       wr_en_ip;
  logic       rd_en_ip;
  logic       irq_op;

  int errors = 0;
  int checks = 0;

  trsq8_timer #(.BASE_ADDR(BASE)) dut (
    .clk_ip   (clk),
    .reset_ip (reset_ip),
    .addr_ip  (addr_ip),
    .data_ip  (data_ip),
    .data_op  (data_op),
    .wr_en_ip (wr_en_ip),
    .rd_en_ip (rd_en_ip),
    .irq_op   (irq_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] m_ctrl;
  logic [7:0] m_period;
  logic [7:0] m_count;
  int         m_pc;
  logic       m_ovf;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl = 8'h00; m_period = 8'hFF; m_count = 8'h00; m_pc = 0; m_ovf = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a, input logic r);
    if (!r || (a >> 2) != (BASE >> 2)) return 8'h00;
    case (a % 4)
      0:       return m_ctrl;
      1:       return m_period;
      2:       return m_count;
      default: return {6'b0, m_ctrl[0], m_ovf};
    endcase
  endfunction

  // One clock of the register-map rules.
  task automatic m_step(input logic rst, input logic [7:0] a, input logic [7:0] d, input logic w);
    logic [7:0] n_ctrl, n_period, n_count;
    int n_pc, off, presc;
    logic hit, did_tick, set_ovf, n_ovf;
    if (rst) begin m_reset(); return; end
    hit = w && ((a >> 2) == (BASE >> 2));
    off = a % 4;
    n_ctrl = m_ctrl; n_period = m_period; n_count = m_count; n_pc = m_pc; n_ovf = m_ovf;
    presc = m_ctrl >> 4;
    did_tick = 1'b0; set_ovf = 1'b0;
    if (m_ctrl[0]) begin
      if (m_pc == presc) begin n_pc = 0; did_tick = 1'b1; end
      else n_pc = (m_pc + 1) % 16;
    end
    if (did_tick && !(hit && off == 2)) begin
      if (m_count >= m_period) begin
        n_count = 0; set_ovf = 1'b1;
        if (!m_ctrl[1]) n_ctrl[0] = 1'b0;
      end else n_count = m_count + 1;
    end
    if (hit) begin
      case (off)
        0: begin n_ctrl = d & 8'hF7; if (!m_ctrl[0] && d[0]) n_pc = 0; end
        1: n_period = d;
        2: n_count = d;
        default: if (d[0]) n_ovf = 1'b0;
      endcase
    end
    if (set_ovf) n_ovf = 1'b1;
    m_ctrl = n_ctrl; m_period = n_period; m_count = n_count; m_pc = n_pc; m_ovf = n_ovf;
  endtask

  // One bus cycle: drive, compare read data and irq against the model (plus an
  // optional fixed expectation), clock, then advance the model.
  task automatic cyc(input logic rst, input logic [7:0] a, input logic [7:0] d,
                     input logic w, input logic r, input logic kc,
                     input logic [7:0] k, input string tag);
    reset_ip = rst; addr_ip = a; data_ip = d; wr_en_ip = w; rd_en_ip = r;
    #3;
    chk("rd_model", data_op, m_read(a, r));
    chk("irq_model", {7'b0, irq_op}, {7'b0, m_ovf & m_ctrl[2]});
    if (kc) chk(tag, data_op, k);
    @(posedge clk);
    m_step(rst, a, d, w);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    cyc(1'b0, BASE + 8'(off), d, 1'b1, 1'b0, 1'b0, 8'h00, "");
  endtask

  task automatic rd(input logic [1:0] off, input logic [7:0] k, input string tag);
    cyc(1'b0, BASE + 8'(off), 8'h00, 1'b0, 1'b1, 1'b1, k, tag);
  endtask

  task automatic irq_is(input logic exp, input string tag);
    chk(tag, {7'b0, irq_op}, {7'b0, exp});
  endtask

  initial begin
    logic [7:0] a, d;
    logic w, r, rst;

    reset_ip = 1'b1; addr_ip = 8'h00; data_ip = 8'h00; wr_en_ip = 1'b0; rd_en_ip = 1'b0;
    @(posedge clk);
    m_reset();
    #1;

    // 1: reset mid-count
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    wr(2'd0, 8'h01);
    wr(2'd2, 8'h05);
    rd(2'd2, 8'h05, "t1_count_pre");
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    irq_is(1'b0, "t1_irq");
    rd(2'd0, 8'h00, "t1_ctrl");
    rd(2'd1, 8'hFF, "t1_period");
    rd(2'd2, 8'h00, "t1_count");
    rd(2'd3, 8'h00, "t1_status");

    // 2: free-run, PRESC=0, auto-reload, irq enabled
    wr(2'd1, 8'h03);
    wr(2'd0, 8'h07);
    rd(2'd2, 8'h00, "t2_count0");
    rd(2'd2, 8'h01, "t2_count1");
    rd(2'd2, 8'h02, "t2_count2");
    irq_is(1'b0, "t2_irq_before");
    rd(2'd2, 8'h03, "t2_count3");
    irq_is(1'b1, "t2_irq_set");
    rd(2'd3, 8'h03, "t2_status");
    wr(2'd3, 8'h01);
    irq_is(1'b0, "t2_irq_clr");
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    irq_is(1'b0, "t2_irq_wait");
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    irq_is(1'b1, "t2_irq_again");
    wr(2'd0, 8'h00);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);

    // 3: prescale by 2, one-shot, irq disabled
    wr(2'd1, 8'h02);
    wr(2'd0, 8'h11);
    rd(2'd2, 8'h00, "t3_c0");
    rd(2'd2, 8'h00, "t3_c1");
    rd(2'd2, 8'h01, "t3_c2");
    rd(2'd2, 8'h01, "t3_c3");
    rd(2'd2, 8'h02, "t3_c4");
    rd(2'd2, 8'h02, "t3_c5");
    rd(2'd0, 8'h10, "t3_ctrl_stopped");
    rd(2'd3, 8'h01, "t3_status");
    rd(2'd2, 8'h00, "t3_count_hold");
    irq_is(1'b0, "t3_irq");
    wr(2'd3, 8'h01);

    // 4a: COUNT write on a tick cycle, PRESC=2
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h21);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    wr(2'd2, 8'h05);
    rd(2'd2, 8'h05, "t4_cnt_a");
    rd(2'd2, 8'h05, "t4_cnt_b");
    rd(2'd2, 8'h05, "t4_cnt_c");
    rd(2'd2, 8'h06, "t4_cnt_d");
    // 4b: STATUS clear on an overflow cycle (PERIOD=0 overflows every tick)
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h07);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    wr(2'd3, 8'h01);
    rd(2'd3, 8'h03, "t4_ovf_kept");
    irq_is(1'b1, "t4_irq_kept");
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h01);
    rd(2'd3, 8'h00, "t4_ovf_cleared");

    // 5: count loaded above PERIOD overflows straight to zero
    wr(2'd1, 8'h04);
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h03);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, "");
    wr(2'd2, 8'hC8);
    rd(2'd2, 8'hC8, "t5_loaded");
    rd(2'd2, 8'h00, "t5_wrapped");
    rd(2'd3, 8'h03, "t5_status");

    // 6: address decode
    cyc(1'b0, BASE + 8'd4, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, "t6_out_window");
    cyc(1'b0, BASE + 8'd1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, "t6_no_rd");
    cyc(1'b0, BASE - 8'd1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, "");
    rd(2'd1, 8'h04, "t6_period_kept");
    rd(2'd0, 8'h03, "t6_ctrl_kept");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 8) a = BASE + 8'($urandom_range(0, 3));
      else a = 8'($urandom);
      w = ($urandom_range(0, 2) == 0);
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (a == BASE && $urandom_range(0, 1) == 1) begin
        d[0] = 1'b1;
        d[7:4] = 4'($urandom_range(0, 2));
      end
      if ((a == BASE + 8'd1 || a == BASE + 8'd2) && $urandom_range(0, 1) == 1)
        d = 8'($urandom_range(0, 7));
      cyc(rst, a, d, w, r, 1'b0, 8'h00, "");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
